// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_ctrl
//  Description : Hazard/stall controller for a 5-stage pipeline: load-use
//                bubbles, branch flushes, data-memory wait with timeout flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic [4:0]  id_ex_rt,
    input  logic        id_ex_mem_read,
    input  logic        branch_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        id_ex_en,
    output logic        ex_mem_en,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic [1:0]  state,
    output logic [15:0] stall_cnt,
    output logic        mem_timeout
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_FLUSH    = 2'b10
    } state_t;

    localparam logic [15:0] c_timeout = 16'(TIMEOUT);

    state_t      r_state;
    state_t      w_state_next;
    logic        r_pend_flush;
    logic        w_pend_next;
    logic [15:0] r_wait_cnt;
    logic [15:0] w_wait_inc;
    logic [15:0] r_stall_cnt;
    logic        r_mem_timeout;

    logic        w_lu;
    logic        w_ms;
    logic        w_pc_en;
    logic        w_if_id_en;
    logic        w_id_ex_en;
    logic        w_ex_mem_en;
    logic        w_if_id_flush;
    logic        w_id_ex_flush;

    assign w_lu = id_ex_mem_read && (id_ex_rt != 5'd0) &&
                  ((id_ex_rt == id_rs) || (id_uses_rt && (id_ex_rt == id_rt)));
    assign w_ms = mem_req && !mem_ready;

    assign w_wait_inc = (r_wait_cnt == 16'hFFFF) ? r_wait_cnt : r_wait_cnt + 16'd1;

    always_comb begin
        w_pc_en       = 1'b1;
        w_if_id_en    = 1'b1;
        w_id_ex_en    = 1'b1;
        w_ex_mem_en   = 1'b1;
        w_if_id_flush = 1'b0;
        w_id_ex_flush = 1'b0;
        w_state_next  = r_state;
        w_pend_next   = r_pend_flush;

        if (w_ms) begin
            // Freeze everything; a branch resolved now is replayed as a flush later.
            w_pc_en      = 1'b0;
            w_if_id_en   = 1'b0;
            w_id_ex_en   = 1'b0;
            w_ex_mem_en  = 1'b0;
            w_state_next = ST_MEM_WAIT;
            w_pend_next  = r_pend_flush | branch_taken;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (branch_taken) begin
                        w_if_id_flush = 1'b1;
                        w_id_ex_flush = 1'b1;
                    end else if (w_lu) begin
                        w_pc_en       = 1'b0;
                        w_if_id_en    = 1'b0;
                        w_id_ex_flush = 1'b1;
                    end
                end
                ST_MEM_WAIT: begin
                    if (!mem_ready) begin
                        w_pc_en     = 1'b0;
                        w_if_id_en  = 1'b0;
                        w_id_ex_en  = 1'b0;
                        w_ex_mem_en = 1'b0;
                        w_pend_next = r_pend_flush | branch_taken;
                    end else begin
                        w_state_next = (r_pend_flush || branch_taken) ? ST_FLUSH : ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    w_if_id_flush = 1'b1;
                    w_id_ex_flush = 1'b1;
                    w_state_next  = ST_RUN;
                end
                default: w_state_next = ST_RUN;
            endcase
        end

        if (w_state_next == ST_FLUSH) begin
            w_pend_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_RUN;
            r_pend_flush  <= 1'b0;
            r_wait_cnt    <= 16'd0;
            r_stall_cnt   <= 16'd0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_pend_flush <= w_pend_next;
            if (!w_pc_en && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if ((r_state != ST_MEM_WAIT) && (w_state_next == ST_MEM_WAIT)) begin
                r_wait_cnt <= 16'd0;
            end else if (r_state == ST_MEM_WAIT) begin
                r_wait_cnt <= w_wait_inc;
            end
            if ((r_state == ST_MEM_WAIT) && (w_wait_inc >= c_timeout)) begin
                r_mem_timeout <= 1'b1;
            end
        end
    end

    // While reset is asserted the pipeline free-runs with no bubbles.
    assign pc_en       = !rst_n || w_pc_en;
    assign if_id_en    = !rst_n || w_if_id_en;
    assign id_ex_en    = !rst_n || w_id_ex_en;
    assign ex_mem_en   = !rst_n || w_ex_mem_en;
    assign if_id_flush = rst_n && w_if_id_flush;
    assign id_ex_flush = rst_n && w_id_ex_flush;

    assign state       = r_state;
    assign stall_cnt   = r_stall_cnt;
    assign mem_timeout = r_mem_timeout;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_ctrl
//  Description : Directed self-checking bench for pipeline_ctrl with a
//                behavioural reference model compared every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;

    localparam int TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  id_rs = '0;
    logic [4:0]  id_rt = '0;
    logic        id_uses_rt = 1'b0;
    logic [4:0]  id_ex_rt = '0;
    logic        id_ex_mem_read = 1'b0;
    logic        branch_taken = 1'b0;
    logic        mem_req = 1'b0;
    logic        mem_ready = 1'b0;
    logic        pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush;
    logic [1:0]  state;
    logic [15:0] stall_cnt;
    logic        mem_timeout;

    pipeline_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_ex_rt(id_ex_rt), .id_ex_mem_read(id_ex_mem_read),
        .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .state(state), .stall_cnt(stall_cnt), .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    // Reference model: mode 0=run, 1=waiting on memory, 2=replaying a flush.
    int m_mode  = 0;
    bit m_pend  = 0;
    int m_stall = 0;
    int m_wait  = 0;
    bit m_tmo   = 0;

    // Expected {pc_en,if_id_en,id_ex_en,ex_mem_en,if_id_flush,id_ex_flush}.
    function automatic logic [5:0] m_out(input int mode);
        logic lu, ms;
        lu = id_ex_mem_read && (id_ex_rt != 0) &&
             ((id_ex_rt == id_rs) || (id_uses_rt && (id_ex_rt == id_rt)));
        ms = mem_req && !mem_ready;
        if (!rst_n) return 6'b111100;
        if (ms) return 6'b000000;
        if (mode == 1) return mem_ready ? 6'b111100 : 6'b000000;
        if (mode == 2) return 6'b111111;
        if (branch_taken) return 6'b111111;
        if (lu) return 6'b001101;
        return 6'b111100;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_pend = 0; m_stall = 0; m_wait = 0; m_tmo = 0;
        end else begin
            logic [5:0] o;
            int nxt;
            o = m_out(m_mode);
            if (!o[5]) m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
            if (m_mode == 1) begin
                m_wait++;
                if (m_wait >= TIMEOUT) m_tmo = 1;
            end
            if (mem_req && !mem_ready) begin
                nxt = 1;
                if (branch_taken) m_pend = 1;
            end else if (m_mode == 1) begin
                if (!mem_ready) begin
                    nxt = 1;
                    if (branch_taken) m_pend = 1;
                end else begin
                    nxt = (m_pend || branch_taken) ? 2 : 0;
                end
            end else begin
                nxt = 0;
            end
            if (nxt == 2) m_pend = 0;
            if (nxt == 1 && m_mode != 1) m_wait = 0;
            m_mode = nxt;
        end
    end

    always @(negedge clk) begin
        chk("outputs", {26'd0, pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush},
            {26'd0, m_out(m_mode)});
        chk("state", {30'd0, state}, m_mode);
        chk("stall_cnt", {16'd0, stall_cnt}, m_stall);
        chk("mem_timeout", {31'd0, mem_timeout}, {31'd0, m_tmo});
    end

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                         input logic [4:0] ert, input logic mrd, input logic br,
                         input logic mq, input logic mr);
        @(posedge clk);
        #1;
        id_rs = rs; id_rt = rt; id_uses_rt = uses; id_ex_rt = ert;
        id_ex_mem_read = mrd; branch_taken = br; mem_req = mq; mem_ready = mr;
        @(negedge clk);
    endtask

    task automatic idle();
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #2;
        chk("rst_state", {30'd0, state}, 0);
        chk("rst_stall", {16'd0, stall_cnt}, 0);
        chk("rst_tmo", {31'd0, mem_timeout}, 0);
        chk("rst_pc_en", {31'd0, pc_en}, 1);
        chk("rst_flush", {31'd0, id_ex_flush}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        idle();
        chk("run_pc_en", {31'd0, pc_en}, 1);

        // load to r5 in EX, ID reads r5
        drive(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("lu_pc_en", {31'd0, pc_en}, 0);
        chk("lu_if_id_en", {31'd0, if_id_en}, 0);
        chk("lu_id_ex_flush", {31'd0, id_ex_flush}, 1);
        chk("lu_id_ex_en", {31'd0, id_ex_en}, 1);
        idle();
        chk("lu_stall1", {16'd0, stall_cnt}, 1);
        chk("lu_after_pc_en", {31'd0, pc_en}, 1);

        // load to r0 never stalls
        drive(5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("r0_pc_en", {31'd0, pc_en}, 1);
        idle();
        chk("r0_stall", {16'd0, stall_cnt}, 1);

        // rt match only counts when rt is a source
        drive(5'd3, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("rt_use_pc_en", {31'd0, pc_en}, 0);
        drive(5'd3, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("rt_nouse_pc_en", {31'd0, pc_en}, 1);

        // branch overrides load-use
        drive(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("br_if_id_flush", {31'd0, if_id_flush}, 1);
        chk("br_id_ex_flush", {31'd0, id_ex_flush}, 1);
        chk("br_pc_en", {31'd0, pc_en}, 1);
        idle();
        chk("br_stall", {16'd0, stall_cnt}, 2);

        // 4-cycle memory stall with a branch in cycle 2
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("ms_pc_en", {31'd0, pc_en}, 0);
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("ms_state", {30'd0, state}, 1);
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("ms_ex_mem_en", {31'd0, ex_mem_en}, 0);
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("ms_ready_state", {30'd0, state}, 1);
        chk("ms_ready_pc_en", {31'd0, pc_en}, 1);
        chk("ms_ready_flush", {31'd0, if_id_flush}, 0);
        idle();
        chk("ms_flush_state", {30'd0, state}, 2);
        chk("ms_flush_if_id", {31'd0, if_id_flush}, 1);
        chk("ms_stall", {16'd0, stall_cnt}, 6);
        idle();
        chk("ms_back_run", {30'd0, state}, 0);

        // long wait: timeout after 255 wait cycles, sticky
        for (int i = 1; i <= 300; i++) begin
            drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            if (i == 256) chk("tmo_before", {31'd0, mem_timeout}, 0);
            if (i == 257) chk("tmo_set", {31'd0, mem_timeout}, 1);
            if (i == 300) chk("tmo_stall", {16'd0, stall_cnt}, 305);
        end
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("tmo_ready", {31'd0, mem_timeout}, 1);
        idle();
        chk("tmo_sticky", {31'd0, mem_timeout}, 1);
        chk("tmo_run", {30'd0, state}, 0);

        // reset mid-wait with a pending flush
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("pre_rst_state", {30'd0, state}, 1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_state", {30'd0, state}, 0);
        chk("arst_stall", {16'd0, stall_cnt}, 0);
        chk("arst_tmo", {31'd0, mem_timeout}, 0);
        chk("arst_pc_en", {31'd0, pc_en}, 1);
        chk("arst_flush", {31'd0, if_id_flush}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1; mem_req = 1'b0; mem_ready = 1'b0; branch_taken = 1'b0;
        @(negedge clk);
        chk("post_rst_state", {30'd0, state}, 0);
        idle();
        chk("post_rst_noflush", {31'd0, if_id_flush}, 0);
        chk("post_rst_state2", {30'd0, state}, 0);
        idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have ports: clk  input  1  pipeline clock; all state updates on its rising edge.
REQ-002 SHALL have ports: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: id_rs  input  5  rs field of the instruction in ID.
REQ-004 SHALL have ports: id_rt  input  5  rt field of the instruction in ID.
REQ-005 SHALL have ports: id_uses_rt  input  1  ID instruction reads rt as a source.
REQ-006 SHALL have ports: id_ex_rt  input  5  rt held in the ID/EX register.
REQ-007 SHALL have ports: id_ex_mem_read  input  1  instruction in EX is a load.
REQ-008 SHALL have ports: branch_taken  input  1  branch/jump resolved taken in EX this cycle.
REQ-009 SHALL have ports: mem_req  input  1  MEM stage is issuing a data-memory access.
REQ-010 SHALL have ports: mem_ready  input  1  data memory completes the access this cycle.
REQ-011 SHALL have outputs pc_en, if_id_en, id_ex_en, ex_mem_en (1 each): stage-register load enables.
REQ-012 SHALL have outputs if_id_flush, id_ex_flush (1 each): load a bubble (all control fields zero) instead of the stage input.
REQ-013 SHALL have outputs state (2, RUN=00, MEM_WAIT=01, FLUSH=10), stall_cnt (16), mem_timeout (1).
REQ-014 SHALL have parameter TIMEOUT, default 255: MEM_WAIT cycles before mem_timeout sets.

Function
REQ-015 Load-use hazard (lu) SHALL be: id_ex_mem_read & id_ex_rt!=0 & (id_ex_rt==id_rs | (id_uses_rt & id_ex_rt==id_rt)).
REQ-016 Memory stall (ms) SHALL be: mem_req & ~mem_ready.
REQ-017 Priority SHALL be ms > branch_taken > lu, evaluated combinationally each cycle.
REQ-018 RUN, no event: all enables 1, both flushes 0.
REQ-019 RUN with lu only: pc_en=0, if_id_en=0, id_ex_flush=1, id_ex_en=1, ex_mem_en=1; stay RUN (single-cycle bubble).
REQ-020 RUN with branch_taken (no ms): if_id_flush=1, id_ex_flush=1, all enables 1; stay RUN; lu ignored that cycle.
REQ-021 ms in any state SHALL drive all enables 0 and flushes 0 in that cycle, then go to MEM_WAIT.
REQ-022 MEM_WAIT: all enables 0, flushes 0; remain while mem_ready=0.
REQ-023 MEM_WAIT with mem_ready=1: enables 1 that cycle; go to FLUSH if pend_flush=1, else RUN.
REQ-024 branch_taken seen while ms or MEM_WAIT SHALL set internal pend_flush; cleared on entry to FLUSH.
REQ-025 FLUSH: if_id_flush=1, id_ex_flush=1, all enables 1, for exactly one cycle, then RUN (or MEM_WAIT if ms).
REQ-026 stall_cnt SHALL increment by 1 each cycle pc_en=0, saturating at 16'hFFFF (no wrap).
REQ-027 Internal wait counter SHALL clear on entering MEM_WAIT and count MEM_WAIT cycles.
REQ-028 mem_timeout SHALL set when the wait counter reaches TIMEOUT and stay set (sticky) until reset.
REQ-029 Enable/flush outputs SHALL be combinational from state and inputs; state, counters and flags are registered.

Reset
REQ-030 rst_n=0 SHALL immediately force state=RUN, pend_flush=0, stall_cnt=0, wait counter=0, mem_timeout=0.
REQ-031 While in reset, enables SHALL be 1 and flushes 0; reset during MEM_WAIT SHALL abandon the wait and any pending flush.
REQ-032 Exit from reset SHALL be synchronous to the first rising clk edge after rst_n rises.

Verification
REQ-033 Load to r5 in EX, ID rs=5 -> one cycle pc_en=0, if_id_en=0, id_ex_flush=1; stall_cnt=1; next cycle all enables 1.
REQ-034 Load to r0 in EX, ID rs=0 -> no stall; stall_cnt stays 0.
REQ-035 branch_taken=1 with lu=1 same cycle -> if_id_flush=1, id_ex_flush=1, pc_en=1; no stall.
REQ-036 mem_req=1, mem_ready=0 for 4 cycles with branch_taken pulse in cycle 2 -> enables 0 for 4 cycles, FLUSH one cycle after mem_ready, then RUN; stall_cnt=4.
REQ-037 mem_ready held 0 for 300 cycles -> mem_timeout=1 after 255 MEM_WAIT cycles, still 1 after mem_ready.
REQ-038 rst_n pulsed low mid-MEM_WAIT -> state=00, stall_cnt=0, mem_timeout=0 without a clock edge; no FLUSH afterwards.
